// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding and fixed I2C transfer constants for the RTC reader.
package rtc_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, CHECK} state_t;
    localparam logic [7:0] REG_POINTER = 8'h00;
    localparam logic [1:0] NR_BYTES_TO_SEND = 2'd1;
    localparam logic [1:0] NR_BYTES_TO_READ = 2'd3;
endpackage

// File: rtl/rtc_time_reader_if.sv
// rtc_time_reader_if: command/response signals between the RTC reader and an I2C master.
interface rtc_time_reader_if;
    logic i2cStart;
    logic [6:0] i2cAddress;
    logic [1:0] i2cNrOfBytesToSend;
    logic [0:0][7:0] i2cBytesToSend;
    logic [1:0] i2cNrOfBytesToRead;
    logic [2:0][7:0] i2cBytesToRead;
    logic i2cReady;
    logic i2cClockStretchTimeoutReached;
    modport master (
        output i2cStart, i2cAddress, i2cNrOfBytesToSend, i2cBytesToSend, i2cNrOfBytesToRead,
        input i2cBytesToRead, i2cReady, i2cClockStretchTimeoutReached
    );
    modport slave (
        input i2cStart, i2cAddress, i2cNrOfBytesToSend, i2cBytesToSend, i2cNrOfBytesToRead,
        output i2cBytesToRead, i2cReady, i2cClockStretchTimeoutReached
    );
endinterface

// File: rtl/rtc_time_reader_bcd_range_check.sv
// bcd_range_check: true when value is two valid BCD digits not exceeding max.
module bcd_range_check (
    input  logic [7:0] value,
    input  logic [7:0] max,
    output logic       ok
);
    assign ok = value[7:4] <= 4'd9 && value[3:0] <= 4'd9 && value <= max;
endmodule

// File: rtl/rtc_time_reader.sv
// rtc_time_reader: polls an I2C RTC for seconds/minutes/hours, validates the BCD
// reading and publishes it with a change pulse and a saturating error count.
module rtc_time_reader
    import rtc_pkg::*;
#(
    parameter int         ClockFrequency     = 24_000_000,
    parameter int         PollPeriodMs       = 100,
    parameter logic [6:0] DeviceAddress      = 7'h68,
    parameter int         ReadyTimeoutCycles = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              refresh,
    rtc_time_reader_if.master bus,
    output logic [7:0]        seconds,
    output logic [7:0]        minutes,
    output logic [7:0]        hours,
    output logic              timeValid,
    output logic              updated,
    output logic [7:0]        errorCount
);
    localparam logic [31:0] PollLast = 32'(ClockFrequency / 1000 * PollPeriodMs - 1);
    localparam logic [31:0] WaitLast = 32'(ReadyTimeoutCycles - 1);

    state_t state, state_next;
    logic [31:0] poll_cnt, wait_cnt;
    logic [7:0] sec_in, min_in, hr_in;
    logic sec_ok, min_ok, hr_ok, start, load, record_error;

    assign bus.i2cStart = start;
    assign bus.i2cAddress = DeviceAddress;
    assign bus.i2cNrOfBytesToSend = NR_BYTES_TO_SEND;
    assign bus.i2cBytesToSend[0] = REG_POINTER;
    assign bus.i2cNrOfBytesToRead = NR_BYTES_TO_READ;

    // CH bit of seconds and the 12/24 control bits of hours are not part of the time
    assign sec_in = bus.i2cBytesToRead[0] & 8'h7F;
    assign min_in = bus.i2cBytesToRead[1];
    assign hr_in  = bus.i2cBytesToRead[2] & 8'h3F;

    bcd_range_check u_sec (.value(sec_in), .max(8'h59), .ok(sec_ok));
    bcd_range_check u_min (.value(min_in), .max(8'h59), .ok(min_ok));
    bcd_range_check u_hr  (.value(hr_in),  .max(8'h23), .ok(hr_ok));

    always_comb begin
        state_next = state;
        start = 1'b0;
        load = 1'b0;
        record_error = 1'b0;
        case (state)
            IDLE: state_next = (refresh || poll_cnt == PollLast) ? START : IDLE;
            START: begin
                start = bus.i2cReady;
                state_next = bus.i2cReady ? WAIT_BUSY : START;
            end
            WAIT_BUSY: begin
                record_error = bus.i2cReady && wait_cnt == WaitLast;
                state_next = !bus.i2cReady ? WAIT_DONE : record_error ? IDLE : WAIT_BUSY;
            end
            WAIT_DONE: begin
                record_error = !bus.i2cReady && bus.i2cClockStretchTimeoutReached;
                state_next = bus.i2cReady ? CHECK : record_error ? IDLE : WAIT_DONE;
            end
            CHECK: begin
                load = sec_ok && min_ok && hr_ok;
                record_error = !load;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            poll_cnt <= '0;
            wait_cnt <= '0;
            seconds <= 8'h00;
            minutes <= 8'h00;
            hours <= 8'h00;
            timeValid <= 1'b0;
            updated <= 1'b0;
            errorCount <= 8'h00;
        end else begin
            state <= state_next;
            // counter restarts on START entry so polls stay one period apart
            poll_cnt <= (state_next == START && state != START) ? '0 :
                        (poll_cnt == PollLast) ? poll_cnt : poll_cnt + 32'd1;
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 32'd1 : '0;
            updated <= load && {sec_in, min_in, hr_in} != {seconds, minutes, hours};
            if (load) begin
                seconds <= sec_in;
                minutes <= min_in;
                hours <= hr_in;
                timeValid <= 1'b1;
            end
            if (record_error) begin
                errorCount <= (errorCount == 8'hFF) ? errorCount : errorCount + 8'd1;
                timeValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rtc_time_reader.sv
// tb_rtc_time_reader: directed and randomized reads against a decimal-arithmetic
// model of the RTC reader, with a behavioural I2C master responder.
module tb_rtc_time_reader;
    logic clk = 1'b0;
    logic rst, refresh;
    logic [7:0] seconds, minutes, hours, errorCount;
    logic timeValid, updated;
    int checks = 0, failures = 0, upd_pulses = 0;
    logic [7:0] m_s = 0, m_m = 0, m_h = 0, m_err = 0;
    logic m_valid = 0;
    logic [7:0] last_b0 = 8'h00, last_b1 = 8'h00, last_b2 = 8'h00;

    rtc_time_reader_if bus();

    rtc_time_reader #(.PollPeriodMs(1)) dut (
        .clock(clk), .reset(rst), .refresh(refresh), .bus(bus),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .timeValid(timeValid), .updated(updated), .errorCount(errorCount)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (updated === 1'b1) upd_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] enc(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic bit in_range(input int v, input int lim);
        return (v / 16 < 10) && (v % 16 < 10) && ((v / 16) * 10 + v % 16 <= lim);
    endfunction

    task automatic model_error();
        m_err = (m_err == 8'd255) ? m_err : m_err + 8'd1;
        m_valid = 0;
    endtask

    task automatic model_read(input logic [7:0] b0, b1, b2, output int exp_pulse);
        int s, m, h;
        s = b0 % 128; m = b1; h = b2 % 64;
        exp_pulse = 0;
        if (in_range(s, 59) && in_range(m, 59) && in_range(h, 23)) begin
            exp_pulse = (s != m_s || m != m_m || h != m_h) ? 1 : 0;
            m_s = 8'(s); m_m = 8'(m); m_h = 8'(h); m_valid = 1;
        end else model_error();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_sec"}, 32'(seconds), 32'(m_s));
        check({tag, "_min"}, 32'(minutes), 32'(m_m));
        check({tag, "_hr"}, 32'(hours), 32'(m_h));
        check({tag, "_valid"}, 32'(timeValid), 32'(m_valid));
        check({tag, "_errcnt"}, 32'(errorCount), 32'(m_err));
    endtask

    task automatic wait_start(input int limit, output int waited);
        waited = 0;
        while (bus.i2cStart !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        check("start_seen", 32'(bus.i2cStart), 32'd1);
    endtask

    task automatic no_start(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.i2cStart !== 1'b0) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    // mode 0: good completion, mode 1: clock-stretch timeout while busy
    task automatic transact(input string tag, input logic [7:0] b0, b1, b2, input int mode, input int busy);
        int w, p0, exp_p;
        refresh = 1; tick(1); refresh = 0;
        wait_start(20, w);
        p0 = upd_pulses;
        tick(1);
        check({tag, "_start_len"}, 32'(bus.i2cStart), 32'd0);
        bus.i2cReady = 0;
        bus.i2cBytesToRead = {b2, b1, b0};
        tick(busy);
        exp_p = 0;
        if (mode == 1) begin
            bus.i2cClockStretchTimeoutReached = 1; tick(1);
            bus.i2cClockStretchTimeoutReached = 0; bus.i2cReady = 1;
            model_error();
        end else begin
            bus.i2cReady = 1;
            model_read(b0, b1, b2, exp_p);
            last_b0 = b0; last_b1 = b1; last_b2 = b2;
        end
        tick(3);
        check({tag, "_pulses"}, 32'(upd_pulses - p0), 32'(exp_p));
        check_outputs(tag);
    endtask

    initial begin
        int w, w2, p0, exp_p;
        logic [7:0] b0, b1, b2;
        rst = 1; refresh = 0;
        bus.i2cReady = 1; bus.i2cClockStretchTimeoutReached = 0; bus.i2cBytesToRead = '0;
        tick(2);
        rst = 0;
        check_outputs("reset");
        check("reset_upd", 32'(updated), 32'd0);
        check("reset_start", 32'(bus.i2cStart), 32'd0);
        check("addr", 32'(bus.i2cAddress), 32'h68);
        check("nsend", 32'(bus.i2cNrOfBytesToSend), 32'd1);
        check("ptr", 32'(bus.i2cBytesToSend[0]), 32'h00);
        check("nread", 32'(bus.i2cNrOfBytesToRead), 32'd3);

        transact("basic", 8'h56, 8'h34, 8'h12, 0, 2);
        transact("ch_bit", 8'hD9, 8'h34, 8'h12, 0, 3);
        transact("same", 8'hD9, 8'h34, 8'h12, 0, 1);
        transact("bad_min", 8'h10, 8'h60, 8'h12, 0, 2);
        transact("bad_hr", 8'h10, 8'h20, 8'h24, 0, 2);
        transact("bad_nib", 8'h1A, 8'h20, 8'h12, 0, 2);
        transact("hr_mask", 8'h00, 8'h59, 8'hE3, 0, 2);
        transact("stretch", 8'h11, 8'h22, 8'h03, 1, 4);

        // refresh while a transaction is running must not queue another start
        refresh = 1; tick(1); refresh = 0;
        wait_start(20, w);
        tick(1); bus.i2cReady = 0; bus.i2cBytesToRead = {8'h05, 8'h06, 8'h07};
        tick(1); refresh = 1; tick(1); refresh = 0; tick(1);
        bus.i2cReady = 1; model_read(8'h07, 8'h06, 8'h05, exp_p);
        no_start("refresh_ignored", 60);
        check_outputs("refresh_ignored");

        // ready never drops: error exactly ReadyTimeoutCycles cycles into WAIT_BUSY
        refresh = 1; tick(1); refresh = 0;
        wait_start(20, w);
        tick(1);
        check("stall_start_len", 32'(bus.i2cStart), 32'd0);
        tick(4095);
        check("stall_before", 32'(errorCount), 32'(m_err));
        tick(1);
        model_error();
        check_outputs("stall_after");
        transact("after_stall", 8'h45, 8'h07, 8'h21, 0, 2);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                b0 = last_b0; b1 = last_b1; b2 = last_b2;
            end else if ($urandom_range(0, 3) == 0) begin
                b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            end else begin
                b0 = enc($urandom_range(0, 59)) | {$urandom_range(0, 1) == 1, 7'd0};
                b1 = enc($urandom_range(0, 59));
                b2 = enc($urandom_range(0, 23)) | {2'($urandom_range(0, 3)), 6'd0};
            end
            transact("rand", b0, b1, b2, ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(1, 6));
        end

        // reset during WAIT_DONE abandons the read
        refresh = 1; tick(1); refresh = 0;
        wait_start(20, w);
        tick(1); bus.i2cReady = 0; tick(3);
        rst = 1; tick(1); rst = 0;
        m_s = 0; m_m = 0; m_h = 0; m_err = 0; m_valid = 0;
        check_outputs("mid_reset");
        check("mid_reset_upd", 32'(updated), 32'd0);
        check("mid_reset_start", 32'(bus.i2cStart), 32'd0);
        bus.i2cReady = 1;
        no_start("post_reset_quiet", 200);
        transact("post_reset", 8'h33, 8'h44, 8'h15, 0, 2);

        // automatic polling: spacing between starts and no pulse on an identical reading
        wait_start(30000, w);
        tick(1); bus.i2cReady = 0; bus.i2cBytesToRead = {8'h15, 8'h44, 8'h33};
        tick(1); bus.i2cReady = 1; tick(1);
        p0 = upd_pulses;
        wait_start(30000, w2);
        check("poll_spacing", 32'(w2 + 3), 32'd24000);
        tick(1); bus.i2cReady = 0; tick(2); bus.i2cReady = 1;
        model_read(8'h33, 8'h44, 8'h15, exp_p);
        tick(3);
        check("poll_same_pulses", 32'(upd_pulses - p0), 32'(exp_p));
        check_outputs("poll");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
